// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues reads to a
// synchronous instruction memory, buffers returned words in a 2-entry queue
// and hands them to decode under a valid/ready handshake. A taken branch
// flushes the queue and redirects the PC.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               dec_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruccion,
  output logic [ADDR_W-1:0]  dirIntruction,
  output logic [ADDR_W-1:0]  pc_plus8
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Architectural and pipeline state
  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        tag_q, tag_d;        // address of the read in flight
  logic                     inflight_q, inflight_d;
  logic                     squash_q, squash_d;

  // 2-entry instruction queue
  logic [1:0]               count_q, count_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0][INSTR_W-1:0]  q_instr_q, q_instr_d;
  logic [1:0][ADDR_W-1:0]   q_addr_q, q_addr_d;

  // Per-cycle control
  logic                     flush;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [2:0]               occupancy;

  // The low address bits of a redirect are forced to zero, never consumed.
  logic                     unused_tgt_bits;
  assign unused_tgt_bits = ^branch_target[1:0];

  // Handshake, credit check and redirect decisions for this cycle
  always_comb begin
    flush      = (state_q == S_RUN) && branch_taken;
    pop        = (count_q != 2'd0) && dec_ready;
    // A returning word lands one cycle after its issue; a redirect in that
    // same cycle discards it through the flush.
    push       = inflight_q && !squash_q && !flush;
    // Entries queued plus the one on its way, minus the one leaving now,
    // must leave room so the return always has a free slot.
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == S_RUN) && !branch_taken && (occupancy < 3'd2);
  end

  // Next-state computation for FSM, PC, tag and queue
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    squash_d   = flush && inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_instr_d  = q_instr_q;
    q_addr_d   = q_addr_q;

    if ((state_q == S_IDLE) && start) begin
      state_d = S_RUN;
    end

    if (flush) begin
      pc_d     = {branch_target[ADDR_W-1:2], 2'b00};
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + ADDR_W'(4);
        tag_d = pc_q;
      end
      if (push) begin
        q_instr_d[wr_ptr_q] = imem_rdata;
        q_addr_d[wr_ptr_q]  = tag_q;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      // NOTE: the queue storage is reset too; it is only two words and it
      // makes the head outputs read zero after reset instead of X.
      q_instr_q  <= '0;
      q_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_instr_q  <= q_instr_d;
      q_addr_q   <= q_addr_d;
    end
  end

  // Output drive: memory request and queue head
  always_comb begin
    imem_rd_en    = issue;
    imem_addr     = pc_q;
    instr_valid   = (count_q != 2'd0);
    instruccion   = q_instr_q[rd_ptr_q];
    dirIntruction = q_addr_q[rd_ptr_q];
    pc_plus8      = q_addr_q[rd_ptr_q] + ADDR_W'(8);
  end

  // The credit rule must never let a return land in a full queue.
  assert property (@(posedge clk) disable iff (rst)
                   !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances share stimulus, one
// with the default reset PC and one starting just below the address wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dec_ready;

  logic        rd_en_a, rd_en_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        valid_a, valid_b;
  logic [31:0] instr_a, instr_b;
  logic [31:0] dir_a, dir_b;
  logic [31:0] p8_a, p8_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_rd_en(rd_en_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dec_ready(dec_ready), .instr_valid(valid_a), .instruccion(instr_a),
    .dirIntruction(dir_a), .pc_plus8(p8_a)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .start(start),
    .imem_rd_en(rd_en_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dec_ready(dec_ready), .instr_valid(valid_b), .instruccion(instr_b),
    .dirIntruction(dir_b), .pc_plus8(p8_b)
  );

  // Synchronous instruction memories: word = address ^ E000_0000
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= addr_a ^ 32'hE000_0000;
    if (rd_en_b) rdata_b <= addr_b ^ 32'hE000_0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then apply this cycle's inputs and let them settle.
  task automatic cyc(input logic r, input logic s, input logic br,
                     input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; start = s; branch_taken = br; branch_target = tgt; dec_ready = rdy;
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; branch_taken = 1'b0; branch_target = '0; dec_ready = 1'b0;

    // Reset, then idle with start low
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_rd_en",   32'(rd_en_a), 32'd0);
    check("rst_addr",    addr_a,       32'd0);
    check("rst_valid",   32'(valid_a), 32'd0);
    check("rst_instr",   instr_a,      32'd0);
    check("rst_dir",     dir_a,        32'd0);
    check("rst_pc8",     p8_a,         32'd8);
    check("rst_addr_w",  addr_b,       32'hFFFF_FFF8);
    check("rst_pc8_w",   p8_b,         32'd8);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("idle_rd_en", 32'(rd_en_a), 32'd0);
    end

    // Start streaming: cycle 0 has start=1
    cyc(0, 1, 0, 0, 1);
    check("c0_rd_en", 32'(rd_en_a), 32'd0);
    cyc(0, 0, 0, 0, 1);                       // cycle 1
    check("c1_rd_en", 32'(rd_en_a), 32'd1);
    check("c1_addr",  addr_a,       32'd0);
    cyc(0, 0, 0, 0, 1);                       // cycle 2
    check("c2_valid", 32'(valid_a), 32'd0);
    check("c2_addr",  addr_a,       32'd4);
    cyc(0, 0, 0, 0, 1);                       // cycle 3
    check("c3_valid", 32'(valid_a), 32'd1);
    check("c3_dir",   dir_a,        32'd0);
    check("c3_instr", instr_a,      32'hE000_0000);
    check("c3_pc8",   p8_a,         32'd8);
    check("w3_dir",   dir_b,        32'hFFFF_FFF8);
    check("w3_pc8",   p8_b,         32'h0000_0000);
    check("w3_instr", instr_b,      32'h1FFF_FFF8);
    cyc(0, 0, 0, 0, 1);                       // cycle 4
    check("c4_dir",   dir_a,        32'd4);
    check("c4_pc8",   p8_a,         32'd12);
    check("w4_dir",   dir_b,        32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);                       // cycle 5
    check("c5_dir",   dir_a,        32'd8);
    check("c5_pc8",   p8_a,         32'd16);
    check("w5_dir",   dir_b,        32'h0000_0000);
    check("w5_valid", 32'(valid_b), 32'd1);
    cyc(0, 0, 0, 0, 1);                       // cycle 6
    check("c6_dir",   dir_a,        32'd12);
    check("c6_pc8",   p8_a,         32'd20);

    // Decode stalls for cycles 7..11
    cyc(0, 0, 0, 0, 0);                       // cycle 7
    check("c7_dir",   dir_a,        32'd16);
    check("c7_rd_en", 32'(rd_en_a), 32'd0);
    for (int i = 8; i <= 11; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("stall_valid", 32'(valid_a), 32'd1);
      check("stall_dir",   dir_a,        32'd16);
      check("stall_rd_en", 32'(rd_en_a), 32'd0);
      check("stall_count", 32'(dut.count_q), 32'd2);
    end
    cyc(0, 0, 0, 0, 1);                       // cycle 12: release
    check("c12_dir",   dir_a,        32'd16);
    check("c12_rd_en", 32'(rd_en_a), 32'd1);
    check("c12_addr",  addr_a,       32'd24);
    cyc(0, 0, 0, 0, 1);
    check("c13_dir",   dir_a,        32'd20);
    cyc(0, 0, 0, 0, 1);
    check("c14_dir",   dir_a,        32'd24);

    // Branch with a read in flight (cycle 15)
    cyc(0, 0, 1, 32'h0000_0103, 1);
    check("br_head",   dir_a,        32'd28);
    check("br_rd_en",  32'(rd_en_a), 32'd0);
    cyc(0, 0, 0, 0, 1);                       // +1
    check("br1_valid", 32'(valid_a), 32'd0);
    check("br1_addr",  addr_a,       32'h0000_0100);
    check("br1_rd_en", 32'(rd_en_a), 32'd1);
    cyc(0, 0, 0, 0, 1);                       // +2
    check("br2_valid", 32'(valid_a), 32'd0);
    cyc(0, 0, 0, 0, 1);                       // +3
    check("br3_valid", 32'(valid_a), 32'd1);
    check("br3_dir",   dir_a,        32'h0000_0100);
    check("br3_instr", instr_a,      32'hE000_0100);
    cyc(0, 0, 0, 0, 1);
    check("br4_dir",   dir_a,        32'h0000_0104);

    // Back-to-back branches: last one wins
    cyc(0, 0, 1, 32'h0000_0200, 1);
    cyc(0, 0, 1, 32'h0000_0302, 1);
    check("bb_rd_en",  32'(rd_en_a), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("bb1_addr",  addr_a,       32'h0000_0300);
    check("bb1_valid", 32'(valid_a), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("bb2_valid", 32'(valid_a), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("bb3_dir",   dir_a,        32'h0000_0300);
    cyc(0, 0, 0, 0, 1);
    check("bb4_dir",   dir_a,        32'h0000_0304);
    check("bb4_valid", 32'(valid_a), 32'd1);

    // Reset mid-stream with an entry queued
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("mr_valid",  32'(valid_a), 32'd0);
    check("mr_addr",   addr_a,       32'd0);
    check("mr_state",  32'(dut.state_q), 32'd0);
    check("mr_rd_en",  32'(rd_en_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("mr_idle_rd_en", 32'(rd_en_a), 32'd0);
    end
    cyc(0, 1, 0, 0, 1);
    check("rs0_rd_en", 32'(rd_en_a), 32'd0);
    cyc(0, 0, 0, 0, 1);
    check("rs1_rd_en", 32'(rd_en_a), 32'd1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rs3_dir",   dir_a,        32'd0);
    check("rs3_valid", 32'(valid_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
